// File: rtl/count_pkg.sv
`default_nettype none
// ============================================================================
// Module   : count_pkg
// Brief    : Shared constants, FSM state type and saturating-add helper for
//            the count stream checker.
// Revision : 1.0
// ============================================================================
package count_pkg;

    localparam int COUNT_W = 4;
    localparam int WIN_LO  = 7;
    localparam int WIN_HI  = 14;
    localparam int MATCH_W = 4;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Adds d to v and clamps the result at maxv.
    function automatic logic [31:0] sat_add(input logic [31:0] v,
                                            input logic [1:0]  d,
                                            input logic [31:0] maxv);
        logic [32:0] s;
        s = {1'b0, v} + {31'b0, d};
        if (s > {1'b0, maxv}) begin
            return maxv;
        end
        return s[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating up-counter; inc and inc2 each add one per cycle.
// Revision : 1.0
// ============================================================================
module sat_counter
    import count_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         inc2,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    logic [1:0] delta;

    assign delta = {1'b0, inc} + {1'b0, inc2};

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= W'(sat_add(32'(count), delta, 32'(MAX)));
        end
    end

endmodule
`default_nettype wire

// File: rtl/count_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : count_stream_checker
// Brief    : Locks onto an up-counter stream, flags increment and window-flag
//            errors, counts wraps and errors. Option: CHECKER_STICKY_ERR_EN.
// Revision : 1.0
// ============================================================================
module count_stream_checker
    import count_pkg::*;
#(
    parameter int WIDTH    = COUNT_W,
    parameter int LO       = WIN_LO,
    parameter int HI       = WIN_HI,
    parameter int LOCK_CNT = 4,
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              upper_in,
    output logic              locked,
    output logic              seq_err,
    output logic              flag_err,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [ERR_W-1:0]  err_count,
    output logic              err_sticky
);

    localparam logic [WIDTH-1:0]   LO_V   = WIDTH'(LO);
    localparam logic [WIDTH-1:0]   HI_V   = WIDTH'(HI);
    localparam logic [WIDTH-1:0]   MAX_V  = '1;
    localparam logic [MATCH_W-1:0] LOCK_V = MATCH_W'(LOCK_CNT);

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     prev_cnt;
    logic                 prev_valid;
    logic [MATCH_W-1:0]   match_cnt, match_nxt, match_inc;
    logic                 inc_ok, exp_upper;
    logic                 seq_nxt, flag_nxt, wrap_nxt;
    logic                 sticky_block;

    assign inc_ok    = prev_valid && (cnt_in == prev_cnt + WIDTH'(1));
    assign exp_upper = (prev_cnt >= LO_V) && (prev_cnt <= HI_V);
    assign match_inc = match_cnt + MATCH_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        match_nxt = match_cnt;
        seq_nxt   = 1'b0;
        flag_nxt  = 1'b0;
        wrap_nxt  = 1'b0;
        if (en) begin
            case (state)
                HUNT: begin
                    if (!inc_ok) begin
                        match_nxt = '0;
                    end else if (match_inc != LOCK_V) begin
                        match_nxt = match_inc;
                    end else if (sticky_block) begin
                        match_nxt = LOCK_V - MATCH_W'(1);
                    end else begin
                        state_nxt = LOCK;
                        match_nxt = '0;
                    end
                end
                LOCK: begin
                    flag_nxt = (upper_in != exp_upper);
                    if (!inc_ok) begin
                        seq_nxt   = 1'b1;
                        state_nxt = HUNT;
                        match_nxt = '0;
                    end else begin
                        wrap_nxt = (prev_cnt == MAX_V) && (cnt_in == '0);
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    match_nxt = '0;
                end
            endcase
        end
    end

    // locked tracks the state register itself, so it rises with LOCK entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked     <= 1'b0;
            seq_err    <= 1'b0;
            flag_err   <= 1'b0;
            match_cnt  <= '0;
            prev_cnt   <= '0;
            prev_valid <= 1'b0;
        end else begin
            locked    <= (state_nxt == LOCK);
            seq_err   <= seq_nxt;
            flag_err  <= flag_nxt;
            match_cnt <= match_nxt;
            if (en) begin
                prev_cnt   <= cnt_in;
                prev_valid <= 1'b1;
            end
        end
    end

`ifdef CHECKER_STICKY_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky <= 1'b0;
        end else if (seq_nxt || flag_nxt) begin
            err_sticky <= 1'b1;
        end
    end
    assign sticky_block = err_sticky;
`else
    assign err_sticky   = 1'b0;
    assign sticky_block = 1'b0;
`endif

    sat_counter #(.W(WRAP_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wrap_nxt),
        .inc2  (1'b0),
        .count (wrap_count)
    );

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (seq_nxt),
        .inc2  (flag_nxt),
        .count (err_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_count_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_stream_checker
// Brief    : Directed scoreboard bench for count_stream_checker.
// Revision : 1.0
// ============================================================================
module tb_count_stream_checker;

`ifdef CHECKER_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef struct packed {
        logic       lck;
        logic       seq;
        logic       flg;
        logic [7:0] wrap;
        logic [7:0] err;
        logic       stk;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] cnt_in;
    logic       upper_in;
    logic       locked, seq_err, flag_err, err_sticky;
    logic [7:0] wrap_count, err_count;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    count_stream_checker dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .cnt_in     (cnt_in),
        .upper_in   (upper_in),
        .locked     (locked),
        .seq_err    (seq_err),
        .flag_err   (flag_err),
        .wrap_count (wrap_count),
        .err_count  (err_count),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic l, input logic s, input logic f,
                                input logic [7:0] w, input logic [7:0] e,
                                input logic st);
        exp_t x;
        x.lck = l; x.seq = s; x.flg = f; x.wrap = w; x.err = e; x.stk = st;
        return x;
    endfunction

    // Correct window flag for sample c: it describes the previous count.
    function automatic logic up_for(input logic [3:0] c);
        logic [3:0] p;
        p = c - 4'd1;
        return (p >= 4'd7) && (p <= 4'd14);
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("locked",     {7'b0, locked},     {7'b0, e.lck});
            chk("seq_err",    {7'b0, seq_err},    {7'b0, e.seq});
            chk("flag_err",   {7'b0, flag_err},   {7'b0, e.flg});
            chk("wrap_count", wrap_count,         e.wrap);
            chk("err_count",  err_count,          e.err);
            chk("err_sticky", {7'b0, err_sticky}, {7'b0, e.stk});
        end
    end

    task automatic step(input logic e, input logic [3:0] c, input logic u,
                        input logic r, input exp_t x);
        en = e; cnt_in = c; upper_in = u; reset = r;
        @(posedge clk);
        sb.push_back(x);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 4'd0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; cnt_in = 4'd0; upper_in = 1'b0;

        // Clean stream: lock after sample 4, two wraps over 48 samples.
        do_reset();
        for (int k = 0; k < 48; k++) begin
            logic [3:0] c;
            c = 4'(k % 16);
            step(1'b1, c, up_for(c), 1'b0,
                 mk(k >= 4, 0, 0, (k >= 32) ? 8'd2 : (k >= 16) ? 8'd1 : 8'd0, 0, 0));
        end

        // Sequence error 5 -> 9, then relock on 10..13.
        do_reset();
        for (int c = 0; c <= 5; c++)
            step(1'b1, 4'(c), up_for(4'(c)), 1'b0, mk(c >= 4, 0, 0, 0, 0, 0));
        step(1'b1, 4'd9, 1'b0, 1'b0, mk(0, 1, 0, 0, 1, STICKY));
        for (int c = 10; c <= 15; c++)
            step(1'b1, 4'(c), up_for(4'(c)), 1'b0,
                 mk(!STICKY && (c >= 13), 0, 0, 0, 1, STICKY));
        step(1'b1, 4'd0, up_for(4'd0), 1'b0,
             mk(!STICKY, 0, 0, STICKY ? 8'd0 : 8'd1, 1, STICKY));

        // Window-flag error after count 7, then both errors together.
        do_reset();
        for (int c = 0; c <= 7; c++)
            step(1'b1, 4'(c), up_for(4'(c)), 1'b0, mk(c >= 4, 0, 0, 0, 0, 0));
        step(1'b1, 4'd8, 1'b0, 1'b0, mk(1, 0, 1, 0, 1, STICKY));
        step(1'b1, 4'd9, up_for(4'd9), 1'b0, mk(1, 0, 0, 0, 1, STICKY));
        step(1'b1, 4'd3, 1'b0, 1'b0, mk(0, 1, 1, 0, 3, STICKY));

        // Enable gap between 5 and 6, reset mid-lock, then fresh acquisition.
        do_reset();
        for (int c = 0; c <= 5; c++)
            step(1'b1, 4'(c), up_for(4'(c)), 1'b0, mk(c >= 4, 0, 0, 0, 0, 0));
        for (int g = 0; g < 3; g++)
            step(1'b0, 4'd12, 1'b1, 1'b0, mk(1, 0, 0, 0, 0, 0));
        for (int c = 6; c <= 8; c++)
            step(1'b1, 4'(c), up_for(4'(c)), 1'b0, mk(1, 0, 0, 0, 0, 0));
        step(1'b1, 4'd9, up_for(4'd9), 1'b1, mk(0, 0, 0, 0, 0, 0));
        for (int c = 10; c <= 14; c++)
            step(1'b1, 4'(c), up_for(4'(c)), 1'b0, mk(c == 14, 0, 0, 0, 0, 0));

        en = 1'b0;
        for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
        #6;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
